// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable generator: debounced single-step button, free-run divider and step counter.
// Optional macro CLOCK_COUNT_CLEAR_EN adds a synchronous count_clr input that zeroes clock_count.
module cpu_clock_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] RUN_DIV         = 24'd5000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic [6:0]  sw_in,
`ifdef CLOCK_COUNT_CLEAR_EN
    input  logic        count_clr,
`endif
    output logic        cpu_step,
    output logic [15:0] clock_count,
    output logic [6:0]  disp_sel
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

    logic       btn_meta;
    logic       btn_sync;
    logic       run_meta;
    logic       run_sync;
    logic [6:0] sw_meta;

    db_state_t   state;
    db_state_t   state_next;
    logic [15:0] db_cnt;
    logic [15:0] db_cnt_next;
    logic        step_req;

    logic [23:0] div_cnt;
    logic        div_hit;
    logic        step_next;

    // Two-flop synchronizers; disp_sel is the second stage of the switch synchronizer.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            run_meta <= 1'b0;
            run_sync <= 1'b0;
            sw_meta  <= '0;
            disp_sel <= '0;
        end else begin
            btn_meta <= step_btn;
            btn_sync <= btn_meta;
            run_meta <= run_sw;
            run_sync <= run_meta;
            sw_meta  <= sw_in;
            disp_sel <= sw_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state  <= state_next;
            db_cnt <= db_cnt_next;
        end
    end

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;
        step_req    = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_next  = PRESS_WAIT;
                    db_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_next = IDLE;
                end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                    state_next = HELD;
                    step_req   = 1'b1;
                end else begin
                    db_cnt_next = db_cnt + 16'd1;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_next  = RELEASE_WAIT;
                    db_cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_next = HELD;
                end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                    state_next = IDLE;
                end else begin
                    db_cnt_next = db_cnt + 16'd1;
                end
            end
            default: begin
                state_next  = IDLE;
                db_cnt_next = '0;
            end
        endcase
    end

    // Divider idles at zero in single-step mode so free-run always starts a full period late.
    assign div_hit = run_sync && (div_cnt == RUN_DIV - 24'd1);

    always_ff @(posedge clock) begin
        if (reset || !run_sync || div_hit) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 24'd1;
        end
    end

    // Button requests are dropped in free-run; the last term keeps pulses at least one cycle apart.
    assign step_next = ((step_req && !run_sync) || div_hit) && !cpu_step;

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_step <= 1'b0;
        end else begin
            cpu_step <= step_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clock_count <= '0;
`ifdef CLOCK_COUNT_CLEAR_EN
        end else if (count_clr) begin
            clock_count <= '0;
`endif
        end else if (cpu_step) begin
            clock_count <= clock_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Self-checking bench for cpu_clock_ctrl (DEBOUNCE_CYCLES=4, RUN_DIV=3) with a run-length reference model.
// Define CLOCK_COUNT_CLEAR_EN for both files to exercise the count_clr port.
module tb_cpu_clock_ctrl;

    localparam logic [15:0] DEB = 16'd4;
    localparam logic [23:0] DIV = 24'd3;

    logic        clock = 1'b0;
    logic        reset;
    logic        step_btn;
    logic        run_sw;
    logic [6:0]  sw_in;
    logic        cpu_step;
    logic [15:0] clock_count;
    logic [6:0]  disp_sel;
`ifdef CLOCK_COUNT_CLEAR_EN
    logic        count_clr;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cpu_clock_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .step_btn   (step_btn),
        .run_sw     (run_sw),
        .sw_in      (sw_in),
`ifdef CLOCK_COUNT_CLEAR_EN
        .count_clr  (count_clr),
`endif
        .cpu_step   (cpu_step),
        .clock_count(clock_count),
        .disp_sel   (disp_sel)
    );

    // Reference model: inputs seen through a 2-sample delay line; a button level is accepted once the
    // delayed button has differed from the accepted level for DEB+1 consecutive samples; free-run
    // fires on every DIV-th consecutive sample of the delayed switch.
    bit [1:0]   m_btn_line;
    bit [1:0]   m_run_line;
    bit [6:0]   m_sw_line [2];
    bit         m_level;
    int         m_run_len;
    int         m_fr_len;
    bit         m_step;
    bit [15:0]  m_count;
    int         preload_seq = 0;
    int         m_seen_seq  = 0;

    always @(posedge clock) begin
        bit nxt;
        bit accept;
        bit clr;
        clr = 1'b0;
`ifdef CLOCK_COUNT_CLEAR_EN
        clr = count_clr;
`endif
        if (preload_seq != m_seen_seq) begin
            m_seen_seq = preload_seq;
            m_count    = 16'hFFFF;
        end
        if (reset) begin
            m_btn_line   = '0;
            m_run_line   = '0;
            m_sw_line[0] = '0;
            m_sw_line[1] = '0;
            m_level      = 1'b0;
            m_run_len    = 0;
            m_fr_len     = 0;
            m_step       = 1'b0;
            m_count      = '0;
        end else begin
            nxt    = 1'b0;
            accept = 1'b0;
            if (m_btn_line[1] != m_level) begin
                m_run_len++;
                if (m_run_len == int'(DEB) + 1) begin
                    m_level   = !m_level;
                    m_run_len = 0;
                    accept    = m_level;
                end
            end else begin
                m_run_len = 0;
            end
            if (m_run_line[1]) begin
                m_fr_len++;
                if (m_fr_len % int'(DIV) == 0) nxt = 1'b1;
            end else begin
                m_fr_len = 0;
            end
            if (accept && !m_run_line[1]) nxt = 1'b1;
            if (m_step) nxt = 1'b0;
            m_count      = clr ? 16'h0000 : m_count + {15'd0, m_step};
            m_step       = nxt;
            m_btn_line   = {m_btn_line[0], step_btn};
            m_run_line   = {m_run_line[0], run_sw};
            m_sw_line[1] = m_sw_line[0];
            m_sw_line[0] = sw_in;
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        step_btn = 1'b0;
        run_sw   = 1'b0;
        sw_in    = '0;
`ifdef CLOCK_COUNT_CLEAR_EN
        count_clr = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        step_btn = 1'b1;
        run_sw   = 1'b1;
        sw_in    = 7'($urandom);
        repeat (4) tick();
        checks++;
        if (cpu_step !== 1'b0) begin
            failures++;
            $display("FAIL reset_cpu_step: got %0b expected 0", cpu_step);
        end
        checks++;
        if (clock_count !== 16'h0000) begin
            failures++;
            $display("FAIL reset_clock_count: got %0h expected 0", clock_count);
        end
        checks++;
        if (disp_sel !== 7'h00) begin
            failures++;
            $display("FAIL reset_disp_sel: got %0h expected 0", disp_sel);
        end
        do_reset();
    endtask

    task automatic test_single_step();
        int pulses = 0;
        int pos    = 0;
        do_reset();
        step_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_step === 1'b1) begin
                pulses++;
                if (pos == 0) pos = i;
            end
        end
        step_btn = 1'b0;
        repeat (12) tick();
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL single_step_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (pos != 7) begin
            failures++;
            $display("FAIL single_step_latency: got %0d expected 7", pos);
        end
        checks++;
        if (clock_count !== 16'd1) begin
            failures++;
            $display("FAIL single_step_count: got %0d expected 1", clock_count);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step_btn = (i % 2 == 0);
            tick();
            if (cpu_step === 1'b1) pulses++;
        end
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cpu_step === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL bounce_pulses: got %0d expected 0", pulses);
        end
        checks++;
        if (clock_count !== 16'd0) begin
            failures++;
            $display("FAIL bounce_count: got %0d expected 0", clock_count);
        end
    endtask

    task automatic test_free_run();
        int pulses  = 0;
        int first   = 0;
        int last    = 0;
        int bad_gap = 0;
        do_reset();
        run_sw = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step_btn = (i >= 8 && i < 22);
            tick();
            if (cpu_step === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
                if (last != 0 && i - last != 3) bad_gap++;
                last = i;
            end
        end
        checks++;
        if (first != 5) begin
            failures++;
            $display("FAIL free_run_first: got %0d expected 5", first);
        end
        checks++;
        if (pulses != 9) begin
            failures++;
            $display("FAIL free_run_pulses: got %0d expected 9", pulses);
        end
        checks++;
        if (bad_gap != 0) begin
            failures++;
            $display("FAIL free_run_period: got %0d bad gaps expected 0", bad_gap);
        end
        checks++;
        if (clock_count !== 16'd9) begin
            failures++;
            $display("FAIL free_run_count: got %0d expected 9", clock_count);
        end
        run_sw   = 1'b0;
        step_btn = 1'b0;
        repeat (15) tick();
        checks++;
        if (clock_count !== m_count) begin
            failures++;
            $display("FAIL free_run_stop_count: got %0d expected %0d", clock_count, m_count);
        end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        do_reset();
        repeat (2) tick();
        // Forcing the counter stands in for the ~65k free-run pulses needed to reach the top value.
        force dut.clock_count = 16'hFFFF;
        preload_seq++;
        tick();
        release dut.clock_count;
        tick();
        checks++;
        if (clock_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload: got %0h expected ffff", clock_count);
        end
        step_btn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cpu_step === 1'b1) pulses++;
        end
        step_btn = 1'b0;
        repeat (12) tick();
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL wrap_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (clock_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_count: got %0h expected 0", clock_count);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int pulses = 0;
        int pos    = 0;
        do_reset();
        step_btn = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (cpu_step !== 1'b0 || clock_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got step=%0b count=%0d expected 0/0", cpu_step, clock_count);
        end
        reset = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (cpu_step === 1'b1) begin
                pulses++;
                if (pos == 0) pos = i;
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL mid_reset_pulses: got %0d expected 1", pulses);
        end
        // Synchronizers restart from zero, so the full 2+4+1 path applies after reset drops.
        checks++;
        if (pos != 7) begin
            failures++;
            $display("FAIL mid_reset_latency: got %0d expected 7", pos);
        end
        step_btn = 1'b0;
        repeat (10) tick();
    endtask

`ifdef CLOCK_COUNT_CLEAR_EN
    task automatic test_count_clr();
        int budget = 0;
        do_reset();
        run_sw = 1'b1;
        repeat (10) tick();
        while (cpu_step !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (cpu_step !== 1'b1) begin
            failures++;
            $display("FAIL count_clr_wait: got no pulse within %0d cycles", budget);
        end
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        checks++;
        if (clock_count !== 16'd0) begin
            failures++;
            $display("FAIL count_clr_priority: got %0d expected 0", clock_count);
        end
        run_sw = 1'b0;
        repeat (5) tick();
    endtask
`endif

    task automatic test_random();
        int  hold = 0;
        bit  prev = 1'b0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                step_btn = 1'($urandom_range(0, 1));
                hold     = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 149) == 0) run_sw = ~run_sw;
            sw_in = 7'($urandom);
            reset = ($urandom_range(0, 399) == 0);
`ifdef CLOCK_COUNT_CLEAR_EN
            count_clr = ($urandom_range(0, 99) == 0);
`endif
            tick();
            checks++;
            if (cpu_step !== m_step) begin
                failures++;
                $display("FAIL rand_cpu_step[%0d]: got %0b expected %0b", n, cpu_step, m_step);
            end
            checks++;
            if (clock_count !== m_count) begin
                failures++;
                $display("FAIL rand_clock_count[%0d]: got %0d expected %0d", n, clock_count, m_count);
            end
            checks++;
            if (disp_sel !== m_sw_line[1]) begin
                failures++;
                $display("FAIL rand_disp_sel[%0d]: got %0h expected %0h", n, disp_sel, m_sw_line[1]);
            end
            checks++;
            if (prev && cpu_step === 1'b1) begin
                failures++;
                $display("FAIL rand_back_to_back[%0d]: got two consecutive pulses expected gap", n);
            end
            prev = (cpu_step === 1'b1);
        end
        reset = 1'b0;
`ifdef CLOCK_COUNT_CLEAR_EN
        count_clr = 1'b0;
`endif
    endtask

    initial begin
        reset    = 1'b1;
        step_btn = 1'b0;
        run_sw   = 1'b0;
        sw_in    = '0;
`ifdef CLOCK_COUNT_CLEAR_EN
        count_clr = 1'b0;
`endif
        @(negedge clock);
        test_reset();
        test_single_step();
        test_bounce();
        test_free_run();
        test_wrap();
        test_reset_mid_debounce();
`ifdef CLOCK_COUNT_CLEAR_EN
        test_count_clr();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
